// File: rtl/input_debounce_sync.sv
// Per-channel input conditioning: synchroniser chain, counter-based debounce, edge strobes.
// level_out changes only after the synced input has differed from it for CNT_MAX enabled edges.
module input_debounce_sync #(
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned CNT_MAX     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] busy
);

    localparam int unsigned CntW = $clog2(CNT_MAX + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;

    // Synchroniser keeps running while ena is low so the freshest level is ready on resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        logic [CntW-1:0] cnt_q;
        logic            level_q;
        logic            rise_q;
        logic            fall_q;

        // cnt_q == 0 is the stable state; any non-zero value is a pending change.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (ena) begin
                    if (cnt_q == '0) begin
                        if (s[ch] != level_q) begin
                            if (CNT_MAX == 1) begin
                                level_q <= s[ch];
                                rise_q  <= s[ch];
                                fall_q  <= ~s[ch];
                            end else begin
                                cnt_q <= CntOne;
                            end
                        end
                    end else if (s[ch] == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CntLast) begin
                        level_q <= s[ch];
                        rise_q  <= s[ch];
                        fall_q  <= ~s[ch];
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
            end
        end

        assign level_out[ch] = level_q;
        assign rise[ch]      = rise_q;
        assign fall[ch]      = fall_q;
        assign busy[ch]      = (cnt_q != '0);
    end

endmodule
